pwm: RTL and testbench



---
 rtl/pwm.sv | 82 ++++++++
 tb/tb_pwm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm.sv
// rtl/pwm.sv - prescaled 16-step PWM generator; define PWM_SYNC_UPDATE_EN to latch settings only at period boundaries
module pwm #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] frequency,
  input  logic [CNT_W-1:0] duty_cycle,
  output logic             pwm_out
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] f_act, d_act;
  logic             tick;
  logic             boundary;

  always_comb begin
    // >= rather than == so a mid-count rise of f_act ticks at once instead of wrapping presc
    tick     = presc_q >= (MAX - f_act);
    boundary = tick & (phase_q == MAX);
    presc_d  = tick ? '0 : presc_q + ONE;
    phase_d  = tick ? phase_q + ONE : phase_q;
    pwm_d    = (d_act == MAX) | (phase_q < d_act);
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [CNT_W-1:0] f_act_q, f_act_d;
  logic [CNT_W-1:0] d_act_q, d_act_d;
  logic             load_first_q, load_first_d;

  assign f_act = f_act_q;
  assign d_act = d_act_q;

  always_comb begin
    f_act_d      = f_act_q;
    d_act_d      = d_act_q;
    load_first_d = 1'b0;
    if (load_first_q || boundary) begin
      f_act_d = frequency;
      d_act_d = duty_cycle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_act_q      <= '0;
      d_act_q      <= '0;
      load_first_q <= 1'b1;
    end else begin
      f_act_q      <= f_act_d;
      d_act_q      <= d_act_d;
      load_first_q <= load_first_d;
    end
  end
`else
  assign f_act = frequency;
  assign d_act = duty_cycle;

  logic unused_boundary;
  assign unused_boundary = boundary;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      phase_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// tb/tb_pwm.sv - scoreboard bench for pwm; expectations follow PWM_SYNC_UPDATE_EN when defined
module tb_pwm;

  logic       clk;
  logic       rst;
  logic [3:0] frequency;
  logic [3:0] duty_cycle;
  logic       pwm_out;

`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  pwm dut (
    .clk       (clk),
    .rst       (rst),
    .frequency (frequency),
    .duty_cycle(duty_cycle),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit exp_q[$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_cyc  = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, n_cyc, act, exp);
    end
  endtask

  // monitor: the output is presented every clock, so one expectation is consumed per edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (exp_q.size() > 0) check("pwm_out", pwm_out, exp_q.pop_front());
    end
  end

  // inputs for the coming edge plus the pwm_out expected right after it
  task automatic drive(input int f, input int d, input logic r, input bit e);
    @(negedge clk);
    frequency  = 4'(f);
    duty_cycle = 4'(d);
    rst        = r;
    exp_q.push_back(e);
  endtask

  // closed form for constant F/D, k = edges since reset release
  function automatic bit exp_steady(input int f, input int d, input int k);
    int t, m, ph;
    t = 16 - f;
    m = k - 1;
    if (SYNC && k == 1) return 1'b0;
    if (SYNC && t == 1) ph = (m - 1) % 16;
    else                ph = (m / t) % 16;
    return (d == 15) || (ph < d);
  endfunction

  task automatic run_const(input int f, input int d, input int n);
    drive(f, d, 1'b1, 1'b0);
    for (int k = 1; k <= n; k++) drive(f, d, 1'b0, exp_steady(f, d, k));
  endtask

  initial begin
    rst        = 1'b1;
    frequency  = 4'd0;
    duty_cycle = 4'd0;
    #2;
    check("reset_async", pwm_out, 1'b0);
    drive(0, 0, 1'b1, 1'b0);
    drive(0, 0, 1'b1, 1'b0);

    run_const(15, 2, 48);
    run_const(15, 8, 48);
    run_const(15, 12, 48);
    run_const(15, 15, 48);
    run_const(4, 2, 400);
    run_const(4, 0, 200);

    // duty 8 -> 12 once phase reaches 3
    drive(15, 8, 1'b1, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      int d_in, d_eff, ph;
      bit e;
      if (SYNC) begin
        d_in  = (k >= 5) ? 12 : 8;
        d_eff = (k >= 18) ? 12 : 8;
        ph    = (k - 2) % 16;
        e     = (k == 1) ? 1'b0 : (ph < d_eff);
      end else begin
        d_in  = (k >= 4) ? 12 : 8;
        ph    = (k - 1) % 16;
        e     = (ph < d_in);
      end
      drive(15, d_in, 1'b0, e);
    end

    // frequency 0 -> 15 while presc holds 10
    drive(0, 8, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      int f_in, m, ph;
      bit e;
      f_in = (k >= 11) ? 15 : 0;
      m    = k - 1;
      if (SYNC) begin
        e = (k == 1) ? 1'b0 : ((m / 16) < 8);
      end else begin
        ph = (m <= 10) ? 0 : ((m - 10) % 16);
        e  = (ph < 8);
      end
      drive(f_in, 8, 1'b0, e);
    end

    // reset asserted mid high phase, then restart from phase 0
    run_const(15, 12, 6);
    @(posedge clk);
    #3;
    check("high_before_reset", pwm_out, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_mid_period", pwm_out, 1'b0);
    for (int k = 0; k < 3; k++) drive(15, 12, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) drive(15, 12, 1'b0, exp_steady(15, 12, k));

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
